// File: rtl/sdf_wr_arbiter_pkg.sv
// Shared definitions for the SDF write-side arbiter and related dataflow arbiters.
package sdf_wr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

  localparam int unsigned SDF_WIDTH = 8;
  localparam int unsigned SDF_BURST = 2;

  // Ceiling log2; returns 0 for values 0 and 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = (value > 0) ? value - 1 : 0;
    r = 0;
    while (v > 0) begin
      v = v >> 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sdf_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after i_ptr, wrapping mod N.
module sdf_wr_arbiter_rr_pick
  import sdf_wr_arbiter_pkg::*;
#(
  parameter int unsigned N  = 2,
  parameter int unsigned PW = (clog2(N) > 0) ? clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_idx,
  output logic          o_valid
);

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    // Upper segment [ptr, N) has priority over the wrapped segment [0, ptr).
    for (int i = 0; i < int'(N); i++) begin
      if (!o_valid && i_req[i] && (i >= int'(i_ptr))) begin
        o_valid  = 1'b1;
        o_gnt[i] = 1'b1;
        o_idx    = PW'(i);
      end
    end
    for (int i = 0; i < int'(N); i++) begin
      if (!o_valid && i_req[i] && (i < int'(i_ptr))) begin
        o_valid  = 1'b1;
        o_gnt[i] = 1'b1;
        o_idx    = PW'(i);
      end
    end
  end

endmodule

// File: rtl/sdf_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N SDF producers, locked per burst.
// Optional sticky protocol-error flag enabled by defining SDF_WR_ARB_ERR_EN.
module sdf_wr_arbiter
  import sdf_wr_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = SDF_WIDTH,
  parameter int unsigned N     = 2,
  parameter int unsigned BURST = SDF_BURST
) (
  input  logic               ck,
  input  logic               rst,
  input  logic [N-1:0]       in_req,
  input  logic [N-1:0]       in_wr,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_full,
  output logic               fifo_wr,
  output logic [WIDTH-1:0]   fifo_data,
  input  logic               fifo_full,
  output logic [N-1:0]       grant,
  output logic               busy,
  output logic               err
);

  localparam int unsigned PW = (clog2(N) > 0) ? clog2(N) : 1;
  localparam int unsigned CW = clog2(BURST) + 1;
  localparam logic [CW-1:0] LAST = CW'(BURST - 1);
  localparam logic [PW-1:0] PTR_MAX = PW'(N - 1);

  state_e          r_state, w_state_d;
  logic [N-1:0]    r_grant, w_grant_d;
  logic [PW-1:0]   r_idx, w_idx_d;
  logic [PW-1:0]   r_rr_ptr, w_rr_ptr_d;
  logic [CW-1:0]   r_cnt, w_cnt_d;

  logic [N-1:0]    w_pick_gnt;
  logic [PW-1:0]   w_pick_idx;
  logic            w_pick_valid;
  logic            w_own_wr;

  sdf_wr_arbiter_rr_pick #(
    .N  (N),
    .PW (PW)
  ) u_rr_pick (
    .i_req   (in_req),
    .i_ptr   (r_rr_ptr),
    .o_gnt   (w_pick_gnt),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  // Owner data path is a pure mux; non-owners always see full.
  always_comb begin
    in_full   = '1;
    fifo_wr   = 1'b0;
    fifo_data = '0;
    w_own_wr  = 1'b0;
    if (r_state == ST_LOCK) begin
      for (int i = 0; i < int'(N); i++) begin
        if (r_grant[i]) begin
          in_full[i] = fifo_full;
          fifo_data  = in_data[i*WIDTH +: WIDTH];
          w_own_wr   = in_wr[i];
        end
      end
      fifo_wr = w_own_wr & ~fifo_full;
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_grant_d  = r_grant;
    w_idx_d    = r_idx;
    w_rr_ptr_d = r_rr_ptr;
    w_cnt_d    = r_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) begin
          w_state_d = ST_LOCK;
          w_grant_d = w_pick_gnt;
          w_idx_d   = w_pick_idx;
          w_cnt_d   = '0;
        end
      end
      ST_LOCK: begin
        if (fifo_wr) begin
          if (r_cnt == LAST) begin
            w_state_d  = ST_IDLE;
            w_grant_d  = '0;
            w_cnt_d    = '0;
            w_rr_ptr_d = (r_idx == PTR_MAX) ? '0 : r_idx + 1'b1;
          end else begin
            w_cnt_d = r_cnt + 1'b1;
          end
        end
      end
      default: w_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_idx    <= '0;
      r_rr_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_d;
      r_grant  <= w_grant_d;
      r_idx    <= w_idx_d;
      r_rr_ptr <= w_rr_ptr_d;
      r_cnt    <= w_cnt_d;
    end
  end

  assign grant = r_grant;
  assign busy  = (r_state == ST_LOCK);

`ifdef SDF_WR_ARB_ERR_EN
  logic r_err;
  logic w_err_set;

  // r_grant is zero outside LOCK, so owner terms only fire mid-burst.
  assign w_err_set = (|(in_wr & ~r_grant))
                   | ((|(in_wr & r_grant)) & fifo_full)
                   | ((r_state == ST_LOCK) & ~(|(in_req & r_grant)));

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= r_err | w_err_set;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sdf_wr_arbiter.sv
// Self-checking bench for sdf_wr_arbiter: N=2/BURST=2 and N=4/BURST=1 instances.
module tb_sdf_wr_arbiter;

`ifdef SDF_WR_ARB_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic ck = 1'b0;
  logic rst;
  always #5 ck = ~ck;

  // Instance A: N=2, BURST=2
  logic [1:0]  a_req, a_wr, a_in_full, a_grant;
  logic [15:0] a_din;
  logic        a_fifo_wr, a_ff, a_busy, a_err;
  logic [7:0]  a_fdata;
  // Instance B: N=4, BURST=1
  logic [3:0]  b_req, b_wr, b_in_full, b_grant;
  logic [31:0] b_din;
  logic        b_fifo_wr, b_ff, b_busy, b_err;
  logic [7:0]  b_fdata;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] a_q[$];
  logic [7:0] b_q[$];

  logic a_auto, b_auto;
  int   a_tok[2];
  int   b_tok[4];
  logic [1:0] a_acc;
  logic [3:0] b_acc;

  logic [1:0] t2_exp[10] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00};
  logic [3:0] t6_exp[11] = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1, 4'h0};

  sdf_wr_arbiter #(.WIDTH(8), .N(2), .BURST(2)) u_dut_a (
    .ck        (ck),
    .rst       (rst),
    .in_req    (a_req),
    .in_wr     (a_wr),
    .in_data   (a_din),
    .in_full   (a_in_full),
    .fifo_wr   (a_fifo_wr),
    .fifo_data (a_fdata),
    .fifo_full (a_ff),
    .grant     (a_grant),
    .busy      (a_busy),
    .err       (a_err)
  );

  sdf_wr_arbiter #(.WIDTH(8), .N(4), .BURST(1)) u_dut_b (
    .ck        (ck),
    .rst       (rst),
    .in_req    (b_req),
    .in_wr     (b_wr),
    .in_data   (b_din),
    .in_full   (b_in_full),
    .fifo_wr   (b_fifo_wr),
    .fifo_data (b_fdata),
    .fifo_full (b_ff),
    .grant     (b_grant),
    .busy      (b_busy),
    .err       (b_err)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  // Scoreboards: every FIFO write must match the oldest expected token.
  always @(negedge ck) begin
    if (a_fifo_wr === 1'b1) begin
      if (a_q.size() == 0) check("a_unexpected_wr", 32'(a_fifo_wr), 32'd0);
      else check("a_fifo_data", 32'(a_fdata), 32'(a_q.pop_front()));
    end
    if (b_fifo_wr === 1'b1) begin
      if (b_q.size() == 0) check("b_unexpected_wr", 32'(b_fifo_wr), 32'd0);
      else check("b_fifo_data", 32'(b_fdata), 32'(b_q.pop_front()));
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    a_req = '0; a_wr = '0; a_din = '0; a_ff = 1'b0; a_auto = 1'b0;
    b_req = '0; b_wr = '0; b_din = '0; b_ff = 1'b0; b_auto = 1'b0;
    #1;
    check("rst_grant", 32'(a_grant), 32'd0);
    check("rst_in_full", 32'(a_in_full), 32'h3);
    check("rst_fifo_wr", 32'(a_fifo_wr), 32'd0);
    check("rst_fifo_data", 32'(a_fdata), 32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_err", 32'(a_err), 32'd0);
    check("rst_b_in_full", 32'(b_in_full), 32'hF);
    step();
    rst = 1'b0;
  endtask

  // Protocol-respecting producers: write whenever not back-pressured.
  task automatic a_drive_auto();
    for (int i = 0; i < 2; i++) begin
      a_wr[i] = a_auto & ~a_in_full[i];
      a_din[i*8 +: 8] = 8'(160 + 16 * i + a_tok[i]);
    end
  endtask

  task automatic b_drive_auto();
    for (int i = 0; i < 4; i++) begin
      b_wr[i] = b_auto & ~b_in_full[i];
      b_din[i*8 +: 8] = 8'(16 * i + b_tok[i]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    do_reset();

    // Single actor, two-token burst
    a_req = 2'b01;
    @(negedge ck); check("t1_grant_lat", 32'(a_grant), 32'd0);
    step();
    a_wr = 2'b01; a_din = 16'h0001; a_q.push_back(8'h01);
    @(negedge ck);
    check("t1_grant", 32'(a_grant), 32'h1);
    check("t1_busy", 32'(a_busy), 32'd1);
    check("t1_in_full", 32'(a_in_full), 32'h2);
    step();
    a_din = 16'h0002; a_q.push_back(8'h02);
    @(negedge ck); check("t1_grant_hold", 32'(a_grant), 32'h1);
    step();
    a_wr = '0; a_req = '0; a_din = '0;
    @(negedge ck);
    check("t1_release", 32'(a_grant), 32'd0);
    check("t1_busy_off", 32'(a_busy), 32'd0);
    check("t1_idle_data", 32'(a_fdata), 32'd0);
    check("t1_drained", 32'(a_q.size()), 32'd0);
    step();

    // Two continuous requesters: A,A,bubble,B,B,bubble,A,A
    do_reset();
    a_q.push_back(8'hA0); a_q.push_back(8'hA1);
    a_q.push_back(8'hB0); a_q.push_back(8'hB1);
    a_q.push_back(8'hA2); a_q.push_back(8'hA3);
    a_tok = '{0, 0};
    a_auto = 1'b1;
    for (int c = 0; c < 10; c++) begin
      a_req = (c < 9) ? 2'b11 : 2'b00;
      if (c == 9) a_auto = 1'b0;
      #1;
      a_drive_auto();
      @(negedge ck);
      check("t2_grant", 32'(a_grant), 32'(t2_exp[c]));
      a_acc = a_wr & ~a_in_full;
      step();
      for (int i = 0; i < 2; i++) if (a_acc[i]) a_tok[i]++;
    end
    a_wr = '0;
    check("t2_drained", 32'(a_q.size()), 32'd0);

    // Stall under fifo_full
    do_reset();
    a_req = 2'b01;
    step();
    a_wr = 2'b01; a_din = 16'h0005; a_q.push_back(8'h05);
    @(negedge ck); check("t3_grant", 32'(a_grant), 32'h1);
    step();
    a_din = 16'h0006; a_ff = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge ck);
      check("t3_stall_wr", 32'(a_fifo_wr), 32'd0);
      check("t3_stall_full", 32'(a_in_full), 32'h3);
      check("t3_stall_grant", 32'(a_grant), 32'h1);
      step();
    end
    a_ff = 1'b0; a_q.push_back(8'h06);
    @(negedge ck); check("t3_unstall_full", 32'(a_in_full), 32'h2);
    step();
    a_wr = '0; a_req = '0; a_din = '0;
    @(negedge ck);
    check("t3_release", 32'(a_grant), 32'd0);
    check("t3_drained", 32'(a_q.size()), 32'd0);
    step();

    // Non-owner write is ignored
    do_reset();
    a_req = 2'b01;
    step();
    a_wr = 2'b11; a_din = 16'h9907; a_q.push_back(8'h07);
    @(negedge ck); check("t4_in_full", 32'(a_in_full), 32'h2);
    step();
    a_wr = 2'b01; a_din = 16'h0008; a_q.push_back(8'h08);
    @(negedge ck);
    check("t4_err", 32'(a_err), 32'(EXP_ERR));
    check("t4_grant", 32'(a_grant), 32'h1);
    step();
    a_wr = '0; a_req = '0; a_din = '0;
    @(negedge ck);
    check("t4_release", 32'(a_grant), 32'd0);
    check("t4_err_sticky", 32'(a_err), 32'(EXP_ERR));
    check("t4_drained", 32'(a_q.size()), 32'd0);
    step();

    // Reset mid-burst abandons the partial burst
    do_reset();
    a_req = 2'b01;
    step();
    a_wr = 2'b01; a_din = 16'h0009; a_q.push_back(8'h09);
    @(negedge ck);
    step();
    a_din = 16'h000A;
    rst = 1'b1;
    #1;
    check("t5_rst_grant", 32'(a_grant), 32'd0);
    check("t5_rst_in_full", 32'(a_in_full), 32'h3);
    check("t5_rst_fifo_wr", 32'(a_fifo_wr), 32'd0);
    check("t5_rst_busy", 32'(a_busy), 32'd0);
    a_wr = '0;
    step();
    rst = 1'b0;
    @(negedge ck); check("t5_idle", 32'(a_grant), 32'd0);
    step();
    a_wr = 2'b01; a_din = 16'h000B; a_q.push_back(8'h0B);
    @(negedge ck); check("t5_regrant", 32'(a_grant), 32'h1);
    step();
    a_din = 16'h000C; a_q.push_back(8'h0C);
    @(negedge ck); check("t5_cnt_restart", 32'(a_grant), 32'h1);
    step();
    a_wr = '0; a_req = '0; a_din = '0;
    @(negedge ck);
    check("t5_release", 32'(a_grant), 32'd0);
    check("t5_drained", 32'(a_q.size()), 32'd0);
    step();

    // N=4, BURST=1: grants rotate 0,1,2,3,0
    do_reset();
    b_q.push_back(8'h00); b_q.push_back(8'h10); b_q.push_back(8'h20);
    b_q.push_back(8'h30); b_q.push_back(8'h01);
    b_tok = '{0, 0, 0, 0};
    b_auto = 1'b1;
    for (int c = 0; c < 11; c++) begin
      b_req = (c < 10) ? 4'hF : 4'h0;
      if (c == 10) b_auto = 1'b0;
      #1;
      b_drive_auto();
      @(negedge ck);
      check("t6_grant", 32'(b_grant), 32'(t6_exp[c]));
      check("t6_busy", 32'(b_busy), 32'(t6_exp[c] != 4'h0));
      b_acc = b_wr & ~b_in_full;
      step();
      for (int i = 0; i < 4; i++) if (b_acc[i]) b_tok[i]++;
    end
    b_wr = '0;
    check("t6_drained", 32'(b_q.size()), 32'd0);
    check("t6_err", 32'(b_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
